// File: rtl/btn_conditioner.sv
// Button front end: polarity correction, two-flop synchroniser, tick-based
// debounce, press/release pulses and keyboard-style auto-repeat.
// All channels share one prescaler; each channel owns its debounce and
// repeat state, so channels never interact.
module btn_conditioner #(
  parameter int             N          = 7,
  parameter logic [N-1:0]   POL        = 7'b1000000,
  parameter int             PRESC_BITS = 16,
  parameter int             DB_TICKS   = 4,
  parameter int             REP_EN     = 1,
  parameter int             REP_DELAY  = 200,
  parameter int             REP_PERIOD = 40,
  parameter int             CW         = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release,
  output logic [N-1:0] btn_event,
  output logic         tick
);

  localparam int DBW    = $clog2(DB_TICKS + 1);
  localparam bit REP_ON = (REP_EN != 0);

  logic [PRESC_BITS-1:0] presc_cnt;
  logic [N-1:0]          sync1;
  logic [N-1:0]          sync2;

  // Free-running prescaler; the tick is the cycle where it is all-ones
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESC_BITS'(1);
    end
  end

  assign tick = &presc_cnt;

  // Polarity-corrected inputs pass through a two-flop synchroniser
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw ^ POL;
      sync2 <= sync1;
    end
  end

  genvar i;
  for (i = 0; i < N; i++) begin : g_ch
    logic           level_r;
    logic           lvl_d;
    logic           rep_q;
    logic [DBW-1:0] db_cnt;
    logic [CW-1:0]  rep_cnt;
    logic           differs;
    logic           flip;
    logic           level_nxt;
    logic           press;

    assign differs   = (sync2[i] != level_r);
    assign flip      = tick && differs && (db_cnt == DBW'(DB_TICKS - 1));
    assign level_nxt = flip ? sync2[i] : level_r;
    assign press     = level_r & ~lvl_d;

    // Debounce: the level flips only after DB_TICKS consecutive disagreeing ticks
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        level_r <= 1'b0;
        db_cnt  <= '0;
      end else if (tick) begin
        if (!differs) begin
          db_cnt <= '0;
        end else if (flip) begin
          level_r <= sync2[i];
          db_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + DBW'(1);
        end
      end
    end

    // Delayed copy of the level for edge detection
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        lvl_d <= 1'b0;
      end else begin
        lvl_d <= level_r;
      end
    end

    // Auto-repeat: load the delay on press, then reload with the period on each expiry;
    // a level that is falling this cycle cancels any repeat due on the same tick
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        rep_cnt <= '0;
        rep_q   <= 1'b0;
      end else begin
        rep_q <= 1'b0;
        if (!level_r || !level_nxt) begin
          rep_cnt <= '0;
        end else if (press) begin
          rep_cnt <= CW'(REP_DELAY);
        end else if (tick) begin
          if (rep_cnt == CW'(1)) begin
            rep_cnt <= CW'(REP_PERIOD);
            rep_q   <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt - CW'(1);
          end
        end
      end
    end

    assign btn_level[i]   = level_r;
    assign btn_press[i]   = press;
    assign btn_release[i] = ~level_r & lvl_d;
    assign btn_event[i]   = press | (rep_q & REP_ON);
  end

endmodule
